fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the pipelined CPU, sitting directly upstream of decode and the register file. It owns the program counter and issues requests to instruction memory over a req/ack handshake. It loads the IF/ID pipeline register (instruction, PC, PC+1) and honours decode stalls and branch/jump redirects, including redirects that arrive while a memory request is still outstanding.

## Interface
- `WIDTH`, 16: instruction width.
- `AW`, 10: PC / instruction-address width.

- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low reset (sampled on rising edge of `clk`).
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  AW  fetch address; valid while `imem_req`=1.
- `imem_ack`  in  1  memory accepts the request; `imem_data` valid this cycle. Zero-wait allowed: may be high in the same cycle `imem_req` rises.
- `imem_data`  in  WIDTH  instruction word, sampled only when `imem_req`=1 and `imem_ack`=1.
- `stall`  in  1  decode cannot accept a new instruction; IF/ID holds.
- `redirect`  in  1  one-cycle pulse: taken branch/jump, flush and refetch.
- `redirect_pc`  in  AW  redirect target, valid with `redirect`.
- `id_valid`  out  1  IF/ID holds a live instruction.
- `id_instr`  out  WIDTH  IF/ID instruction.
- `id_pc`  out  AW  address of `id_instr`.
- `id_pcnext`  out  AW  `id_pc`+1, mod 2^AW.

## Operation
- Registers:
  - `fa`: fetch address; drives `imem_addr`.
  - `tgt`: pending redirect target.
  - `buf`: one-entry instruction holding buffer.
  - IF/ID register.
  - 2-bit FSM.
- Load condition: `can_load` = !`id_valid` | !`stall`.
- FSM states:
  - RST: entered while `reset`=0. `imem_req`=0. `fa`=0, `id_valid`=0, `id_instr`/`id_pc`/`id_pcnext`=0. Goes to REQ on the first edge with `reset`=1.
  - REQ: `imem_req`=1, `imem_addr`=`fa`. The request is never aborted; `fa` is stable until ack. Transitions, in priority order:
    - `redirect` & `imem_ack`: data dropped; `fa`<=`redirect_pc`; `id_valid`<=0; stay REQ.
    - `redirect` & !`imem_ack`: `tgt`<=`redirect_pc`; `id_valid`<=0; go to DRAIN.
    - `imem_ack` & `can_load`: IF/ID <= {`imem_data`, `fa`, `fa`+1}; `id_valid`<=1; `fa`<=`fa`+1; stay REQ.
    - `imem_ack` & !`can_load`: `buf`<=`imem_data`; go to HOLD.
    - No ack: stay REQ.
  - HOLD: `imem_req`=0.
    - `redirect`: `buf` dropped; `fa`<=`redirect_pc`; `id_valid`<=0; go to REQ.
    - Else if `can_load`: IF/ID <= {`buf`, `fa`, `fa`+1}; `fa`<=`fa`+1; go to REQ.
    - Else stay HOLD.
  - DRAIN: `imem_req`=1, `imem_addr`=`fa` (old address); `id_valid` held 0.
    - `redirect`: `tgt`<=`redirect_pc` (latest redirect wins).
    - `imem_ack`: data dropped; `fa` <= (`redirect` ? `redirect_pc` : `tgt`); go to REQ.
- Flush: `redirect` clears `id_valid` next edge in every state, regardless of `stall`.
- Stall with `id_valid`=1: `id_instr`, `id_pc`, `id_pcnext` unchanged.
- Arithmetic: `fa`+1 and `id_pcnext` wrap 2^AW−1 → 0. No carry-out.
- Instruction memory shares `reset`. An `imem_ack` seen in RST is ignored.

## Timing
- Reset value of every output: `imem_req`=0, `imem_addr`=0, `id_valid`=0, `id_instr`=0, `id_pc`=0, `id_pcnext`=0.
- First request: cycle after `reset` deasserts, address 0.
- Fetch latency: ack sampled at edge N → `id_valid`/`id_instr` updated after edge N.
- Throughput: zero-wait memory and no stall → one instruction per cycle, `imem_req` continuously high.
- Redirect penalty:
  - With ack in the same cycle as the redirect: new address presented the next cycle.
  - In DRAIN: new address presented the cycle after the draining ack.
- Stall release:
  - From HOLD: IF/ID loads on the first edge with `can_load`.
  - Next request issued the following cycle.
- `reset`=0 mid-operation: all state returns to RST on that edge, overriding redirect, stall and ack. An outstanding request is abandoned.

## Test plan
- Zero-wait streaming: reset released, `imem_ack`=1 always, `imem_data`=0x1000+addr → `id_pc` 0,1,2,3 on consecutive cycles, `id_instr`=0x1000..0x1003, `id_pcnext`=`id_pc`+1.
- Stall: stall=1 for 3 cycles while `id_pc`=5 → IF/ID frozen at 5, FSM enters HOLD with `imem_req`=0. After release: `id_pc`=6 next edge, request for addr 7 the following cycle.
- Redirect in same cycle as ack at addr 8, `redirect_pc`=0x3F0 → `id_valid`=0 next cycle, `imem_addr`=0x3F0, first valid `id_pc`=0x3F0.
- Redirect while waiting (ack delayed 3 cycles at addr 4, redirect to 0x20, then second redirect to 0x40 in DRAIN) → `imem_addr` stays 4 until ack, data dropped, next request 0x40, no instruction from 4 ever valid.
- Wrap: redirect to 0x3FE, zero-wait → `id_pc` 0x3FE, 0x3FF, 0x000; `id_pcnext` at 0x3FF = 0x000.
- Mid-operation reset: `reset`=0 during DRAIN with ack arriving → next cycle all outputs zero. After release, first request is addr 0.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage: PC ownership, imem req/ack, IF/ID load,
//            decode stall and redirect (including mid-request) handling.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter int WIDTH = 16,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [AW-1:0]    imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             stall,
    input  logic             redirect,
    input  logic [AW-1:0]    redirect_pc,
    output logic             id_valid,
    output logic [WIDTH-1:0] id_instr,
    output logic [AW-1:0]    id_pc,
    output logic [AW-1:0]    id_pcnext
);

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t           state_q;
    logic             req_q;
    logic [AW-1:0]    fa_q;
    logic [AW-1:0]    tgt_q;
    logic [WIDTH-1:0] buf_q;
    logic             id_valid_q;
    logic [WIDTH-1:0] id_instr_q;
    logic [AW-1:0]    id_pc_q;
    logic [AW-1:0]    id_pcnext_q;

    logic             can_load;
    logic [AW-1:0]    fa_inc;

    assign can_load = !id_valid_q || !stall;
    assign fa_inc   = fa_q + {{(AW-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_RST;
            req_q       <= 1'b0;
            fa_q        <= '0;
            tgt_q       <= '0;
            buf_q       <= '0;
            id_valid_q  <= 1'b0;
            id_instr_q  <= '0;
            id_pc_q     <= '0;
            id_pcnext_q <= '0;
        end else begin
            case (state_q)
                S_RST: begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                end
                S_REQ: begin
                    if (redirect && imem_ack) begin
                        fa_q       <= redirect_pc;
                        id_valid_q <= 1'b0;
                    end else if (redirect) begin
                        // Request cannot be aborted: wait out the ack in DRAIN.
                        tgt_q      <= redirect_pc;
                        id_valid_q <= 1'b0;
                        state_q    <= S_DRAIN;
                    end else if (imem_ack && can_load) begin
                        id_instr_q  <= imem_data;
                        id_pc_q     <= fa_q;
                        id_pcnext_q <= fa_inc;
                        id_valid_q  <= 1'b1;
                        fa_q        <= fa_inc;
                    end else if (imem_ack) begin
                        buf_q   <= imem_data;
                        state_q <= S_HOLD;
                        req_q   <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        fa_q       <= redirect_pc;
                        id_valid_q <= 1'b0;
                        state_q    <= S_REQ;
                        req_q      <= 1'b1;
                    end else if (can_load) begin
                        id_instr_q  <= buf_q;
                        id_pc_q     <= fa_q;
                        id_pcnext_q <= fa_inc;
                        id_valid_q  <= 1'b1;
                        fa_q        <= fa_inc;
                        state_q     <= S_REQ;
                        req_q       <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    id_valid_q <= 1'b0;
                    if (redirect) begin
                        tgt_q <= redirect_pc;
                    end
                    if (imem_ack) begin
                        fa_q    <= redirect ? redirect_pc : tgt_q;
                        state_q <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_RST;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = fa_q;
    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;
    assign id_pcnext = id_pcnext_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

    localparam int WIDTH = 16;
    localparam int AW    = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             imem_req;
    logic [AW-1:0]    imem_addr;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_data;
    logic             stall;
    logic             redirect;
    logic [AW-1:0]    redirect_pc;
    logic             id_valid;
    logic [WIDTH-1:0] id_instr;
    logic [AW-1:0]    id_pc;
    logic [AW-1:0]    id_pcnext;
    logic             ack_en;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    // Memory model: returns 0x1000 + address, ack gated by the request.
    assign imem_ack  = ack_en & imem_req;
    assign imem_data = 16'h1000 + {{(WIDTH-AW){1'b0}}, imem_addr};

    fetch_unit #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pcnext   (id_pcnext)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_id(input string tag, input logic [AW-1:0] pc);
        chk({tag, "_valid"},  32'(id_valid),  32'd1);
        chk({tag, "_pc"},     32'(id_pc),     32'(pc));
        chk({tag, "_instr"},  32'(id_instr),  32'h1000 + 32'(pc));
        chk({tag, "_pcnext"}, 32'(id_pcnext), 32'(AW'(pc + 1'b1)));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"},    32'(imem_req),  32'd0);
        chk({tag, "_addr"},   32'(imem_addr), 32'd0);
        chk({tag, "_valid"},  32'(id_valid),  32'd0);
        chk({tag, "_instr"},  32'(id_instr),  32'd0);
        chk({tag, "_pc"},     32'(id_pc),     32'd0);
        chk({tag, "_pcnext"}, 32'(id_pcnext), 32'd0);
    endtask

    initial begin
        reset       = 1'b0;
        ack_en      = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        tick();
        tick();
        chk_zero("rst");

        // Streaming with zero-wait memory
        reset = 1'b1;
        tick();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", 32'(imem_addr), 32'd0);
        chk("first_valid", 32'(id_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_id("stream", AW'(k));
            chk("stream_req", 32'(imem_req), 32'd1);
        end

        // Stall for three cycles while id_pc = 5
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_id("stall", 10'd5);
            chk("stall_req", 32'(imem_req), 32'd0);
        end
        stall = 1'b0;
        tick();
        chk_id("release", 10'd6);
        chk("release_req", 32'(imem_req), 32'd1);
        chk("release_addr", 32'(imem_addr), 32'd7);
        tick();
        chk_id("post_release", 10'd7);
        chk("redir_ack_addr_before", 32'(imem_addr), 32'd8);

        // Redirect coinciding with ack at addr 8
        redirect    = 1'b1;
        redirect_pc = 10'h3F0;
        tick();
        redirect = 1'b0;
        chk("redir_ack_valid", 32'(id_valid), 32'd0);
        chk("redir_ack_addr", 32'(imem_addr), 32'h3F0);
        tick();
        chk_id("redir_ack_first", 10'h3F0);

        // Redirect while a request is outstanding
        redirect    = 1'b1;
        redirect_pc = 10'd4;
        tick();
        redirect = 1'b0;
        ack_en   = 1'b0;
        chk("drain_addr0", 32'(imem_addr), 32'd4);
        tick();
        redirect    = 1'b1;
        redirect_pc = 10'h20;
        tick();
        redirect_pc = 10'h40;
        chk("drain_addr1", 32'(imem_addr), 32'd4);
        chk("drain_req1", 32'(imem_req), 32'd1);
        chk("drain_valid1", 32'(id_valid), 32'd0);
        tick();
        redirect = 1'b0;
        ack_en   = 1'b1;
        chk("drain_addr2", 32'(imem_addr), 32'd4);
        chk("drain_valid2", 32'(id_valid), 32'd0);
        tick();
        chk("drain_newaddr", 32'(imem_addr), 32'h40);
        chk("drain_valid3", 32'(id_valid), 32'd0);
        chk("drain_req3", 32'(imem_req), 32'd1);
        tick();
        chk_id("drain_first", 10'h40);

        // Address wrap
        redirect    = 1'b1;
        redirect_pc = 10'h3FE;
        tick();
        redirect = 1'b0;
        chk("wrap_addr", 32'(imem_addr), 32'h3FE);
        tick();
        chk_id("wrap0", 10'h3FE);
        tick();
        chk_id("wrap1", 10'h3FF);
        tick();
        chk_id("wrap2", 10'h000);

        // Reset asserted during DRAIN with the ack arriving
        ack_en      = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 10'h100;
        tick();
        redirect = 1'b0;
        ack_en   = 1'b1;
        reset    = 1'b0;
        tick();
        chk_zero("midrst");
        reset = 1'b1;
        tick();
        chk("midrst_req", 32'(imem_req), 32'd1);
        chk("midrst_addr", 32'(imem_addr), 32'd0);
        tick();
        chk_id("midrst_first", 10'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
